shift_cmd_sequencer: RTL and testbench

Sequential front-end that feeds the team's combinational 8-bit shifter. It buffers shift commands (data, op, count) in a small FIFO and drives the shifter's din/sel/shift_count inputs from registers. It captures the shifter's dout and returns each result over a valid/ready handshake, so upstream logic can stream shift operations without managing shifter timing.

---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_cmd_fifo.sv | 49 ++++
 rtl/shift_cmd_sequencer.sv | 156 +++++++++++++++
 tb/tb_shift_cmd_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift command sequencer: op codes, command record, FSM states.
// SHIFT_CMD_CHAIN_EN adds a per-command chain bit to shift_cmd_t.
package shift_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [2:0] {
    PASS  = 3'd0,
    SLL   = 3'd1,
    SLA   = 3'd2,
    SRL   = 3'd3,
    SRA   = 3'd4,
    ROL   = 3'd5,
    ROR   = 3'd6,
    PASS2 = 3'd7
  } shift_op_e;

  typedef struct packed {
    logic [W_DEFAULT-1:0] data;
    shift_op_e            op;
    logic [2:0]           count;
`ifdef SHIFT_CMD_CHAIN_EN
    logic                 chain;
`endif
  } shift_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous show-ahead FIFO of shift commands; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate occupancy counter.
module shift_cmd_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  shift_cmd_t i_wdata,
  input  logic       i_pop,
  output shift_cmd_t o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  shift_cmd_t   r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone decide which slots hold valid data.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Front-end for the combinational shifter: queues commands, drives the shifter from
// registers, captures its output and hands results off over valid/ready.
// Optional SHIFT_CMD_CHAIN_EN: chained commands take sh_din from the last captured result.
module shift_cmd_sequencer
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_data,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_count,
`ifdef SHIFT_CMD_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [W-1:0]     sh_din,
  output logic [2:0]       sh_sel,
  output logic [2:0]       sh_shift_count,
  input  logic [W-1:0]     sh_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [2:0]       res_op,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  seq_state_e       r_state;
  seq_state_e       w_next_state;
  shift_cmd_t       w_wdata;
  shift_cmd_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_capture;
  logic             w_handoff;
  logic [W-1:0]     w_din_src;
  logic [W-1:0]     r_sh_din;
  logic [2:0]       r_sh_sel;
  logic [2:0]       r_sh_count;
  logic             r_res_valid;
  logic [W-1:0]     r_res_data;
  logic [2:0]       r_res_op;
  logic [CNT_W-1:0] r_done_cnt;

  always_comb begin
    w_wdata       = '0;
    w_wdata.data  = cmd_data;
    w_wdata.op    = shift_op_e'(cmd_op);
    w_wdata.count = cmd_count;
`ifdef SHIFT_CMD_CHAIN_EN
    w_wdata.chain = cmd_chain;
`endif
  end

  shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef SHIFT_CMD_CHAIN_EN
  assign w_din_src = w_head.chain ? r_res_data : w_head.data;
`else
  assign w_din_src = w_head.data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_handoff    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_capture    = 1'b1;
        w_next_state = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          w_handoff = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ISSUE;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Shifter inputs change only on a pop, so they are stable through all of ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_din   <= '0;
      r_sh_sel   <= '0;
      r_sh_count <= '0;
    end else if (w_pop) begin
      r_sh_din   <= w_din_src;
      r_sh_sel   <= w_head.op;
      r_sh_count <= w_head.count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_done_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= sh_dout;
        r_res_op    <= r_sh_sel;
      end else if (w_handoff) begin
        r_res_valid <= 1'b0;
        r_done_cnt  <= r_done_cnt + 1'b1;
      end
    end
  end

  assign cmd_ready      = !w_full;
  assign sh_din         = r_sh_din;
  assign sh_sel         = r_sh_sel;
  assign sh_shift_count = r_sh_count;
  assign res_valid      = r_res_valid;
  assign res_data       = r_res_data;
  assign res_op         = r_res_op;
  assign busy           = !w_empty || (r_state != IDLE);
  assign done_cnt       = r_done_cnt;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer with a behavioural 8-bit shifter on the sh_* bus.
// Define SHIFT_CMD_CHAIN_EN to also exercise chained commands.
module tb_shift_cmd_sequencer;
  import shift_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_data;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_count;
  logic             cmd_chain;
  logic [W-1:0]     sh_din;
  logic [2:0]       sh_sel;
  logic [2:0]       sh_shift_count;
  logic [W-1:0]     sh_dout;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;
  logic [2:0]       res_op;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  always #5 clk = ~clk;

  shift_cmd_sequencer #(.DEPTH(DEPTH), .W(W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .cmd_op         (cmd_op),
    .cmd_count      (cmd_count),
`ifdef SHIFT_CMD_CHAIN_EN
    .cmd_chain      (cmd_chain),
`endif
    .sh_din         (sh_din),
    .sh_sel         (sh_sel),
    .sh_shift_count (sh_shift_count),
    .sh_dout        (sh_dout),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_op         (res_op),
    .busy           (busy),
    .done_cnt       (done_cnt)
  );

  function automatic logic [7:0] shift_ref(input logic [7:0] d, input logic [2:0] op,
                                           input logic [2:0] n);
    logic [7:0]  r;
    logic [15:0] dd;
    dd = {d, d};
    case (shift_op_e'(op))
      SLL, SLA: r = d << n;
      SRL:      r = d >> n;
      SRA:      r = $signed(d) >>> n;
      ROL:      begin dd = dd << n; r = dd[15:8]; end
      ROR:      begin dd = dd >> n; r = dd[7:0];  end
      default:  r = d;
    endcase
    return r;
  endfunction

  assign sh_dout = shift_ref(sh_din, sh_sel, sh_shift_count);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] op;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] op;
    logic [2:0] count;
    logic [7:0] exp;
  } vec_t;

  exp_t             sb_q[$];
  int               hand_cyc[$];
  logic [CNT_W-1:0] exp_done = '0;
  int               cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares each result at its handoff and watches stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [2:0] prev_op;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (res_valid && !res_ready && prev_stall)
        check("stall_stable", {res_data, res_op}, {prev_data, prev_op});
      if (res_valid && res_ready) begin
        exp_t e;
        hand_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_op", res_op, e.op);
        end
        check("done_cnt_at_handoff", done_cnt, exp_done);
        exp_done = exp_done + 1'b1;
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
      prev_op    = res_op;
    end
  end

  // Tasks start and end one time unit after a rising edge.
  task automatic push(input logic [7:0] d, input logic [2:0] op, input logic [2:0] n,
                      input logic ch, input logic [7:0] exp);
    int waited;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_op    = op;
    cmd_count = n;
    cmd_chain = ch;
    for (waited = 0; waited < 200; waited++) begin
      @(negedge clk);
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    if (waited >= 200) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      e.data = exp;
      e.op   = op;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) break;
    end
    check(name, k < 200, 1'b1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[10];
  int   accepted;
  int   lat;
  logic [7:0] bp_d;
  logic [2:0] bp_op;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h9D, SRL,   3'd2, 8'h27};
    vecs[1] = '{8'h9D, SRA,   3'd2, 8'hE7};
    vecs[2] = '{8'h9D, ROL,   3'd2, 8'h76};
    vecs[3] = '{8'h9D, ROR,   3'd2, 8'h67};
    vecs[4] = '{8'h9D, PASS,  3'd0, 8'h9D};
    vecs[5] = '{8'h9D, PASS2, 3'd7, 8'h9D};
    vecs[6] = '{8'h80, SRA,   3'd7, 8'hFF};
    vecs[7] = '{8'h01, SLL,   3'd7, 8'h80};
    vecs[8] = '{8'hF0, SRL,   3'd4, 8'h0F};
    vecs[9] = '{8'h81, ROL,   3'd7, 8'hC0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_op = '0; cmd_count = '0;
    cmd_chain = 1'b0; res_ready = 1'b0;
    #12;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done_cnt", done_cnt, '0);
    check("rst_res", {res_data, res_op}, '0);
    check("rst_sh", {sh_din, sh_sel, sh_shift_count}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single op and first-result latency.
    res_ready = 1'b1;
    push(8'h9D, SLL, 3'd2, 1'b0, 8'h74);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (res_valid) begin lat = k; break; end
    end
    check("first_result_latency", lat, 3);
    drain("drain_single");
    check("done_cnt_after_single", done_cnt, 2'd1);
    check("sh_hold_in_idle", {sh_din, sh_sel, sh_shift_count}, {8'h9D, 3'd1, 3'd2});

    // Table stream, back-to-back pushes with res_ready high.
    hand_cyc.delete();
    foreach (vecs[i]) push(vecs[i].data, vecs[i].op, vecs[i].count, 1'b0, vecs[i].exp);
    drain("drain_table");
    check("table_result_count", hand_cyc.size(), 10);
    for (int i = 1; i < hand_cyc.size(); i++)
      check($sformatf("throughput_gap_%0d", i), hand_cyc[i] - hand_cyc[i-1], 2);
    check("done_cnt_wrapped", done_cnt, 2'd3);

    // Backpressure until full, then release and drain in order.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      bp_d = 8'h9D ^ 8'(i * 19); bp_op = 3'(i + 1);
      cmd_data = bp_d; cmd_op = bp_op; cmd_count = 3'(i);
      @(negedge clk);
      if (!cmd_ready) break;
      sb_q.push_back('{shift_ref(bp_d, bp_op, 3'(i)), bp_op});
      accepted++;
      @(posedge clk); #1;
    end
    check("accepted_before_full", accepted, DEPTH + 1);
    check("cmd_ready_low_when_full", cmd_ready, 1'b0);
    repeat (4) @(negedge clk);
    check("still_full_while_stalled", cmd_ready, 1'b0);
    check("res_valid_while_stalled", res_valid, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    bp_d = 8'h9D ^ 8'(5 * 19); bp_op = 3'd6;
    push(bp_d, bp_op, 3'd5, 1'b0, shift_ref(bp_d, bp_op, 3'd5));
    drain("drain_backpressure");

    // Asynchronous reset while holding a result with two commands queued.
    res_ready = 1'b0;
    push(8'h12, SLL, 3'd1, 1'b0, 8'h24);
    push(8'h34, SRL, 3'd1, 1'b0, 8'h1A);
    push(8'h56, ROL, 3'd4, 1'b0, 8'h65);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) begin lat = 1; break; end
    end
    check("hold_reached_before_reset", lat, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done_cnt", done_cnt, '0);
    sb_q.delete();
    exp_done = '0;
    hand_cyc.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale_results", hand_cyc.size(), 0);
    check("idle_after_reset", busy, 1'b0);
    @(posedge clk); #1;

`ifdef SHIFT_CMD_CHAIN_EN
    push(8'h9D, ROL, 3'd2, 1'b0, 8'h76);
    push(8'h00, ROR, 3'd2, 1'b1, 8'h9D);
    drain("drain_chain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
